// File: rtl/uart_tx_mmio_ctrl_pkg.sv
// Shared definitions for the memory-mapped UART transmit controller:
// bus decode base, register offsets, serializer states and field positions.
package uart_tx_mmio_ctrl_pkg;

    // addr[31:4] value that selects the UART register window (0x200..0x20F)
    localparam logic [27:0] UART_BASE_ADDRESS = 28'h000_0020;

    localparam int UART_DATA_W = 8;

    typedef enum logic [3:0] {
        REG_STATUS = 4'h0,
        REG_DATA   = 4'h4,
        REG_CTRL   = 4'h8,
        REG_BAUD   = 4'hC
    } uart_reg_address_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

    // STATUS field positions
    localparam int STATUS_BUSY_BIT  = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_EMPTY_BIT = 2;
    localparam int STATUS_OVF_BIT   = 3;
    localparam int STATUS_COUNT_LSB = 4;
    localparam int STATUS_COUNT_MSB = 7;

    // CTRL field positions
    localparam int CTRL_TX_EN_BIT    = 0;
    localparam int CTRL_IRQ_EN_BIT   = 1;
    localparam int CTRL_FIFO_CLR_BIT = 2;

    // A zero divisor would never tick; run it as one clock per bit instead.
    function automatic logic [15:0] baud_div_eff(input logic [15:0] div);
        return (div == 16'd0) ? 16'd1 : div;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO for queued TX bytes. A push into a full FIFO
// is accepted only when a pop frees a slot in the same cycle; clear has
// priority over both push and pop.
module uart_tx_fifo
    import uart_tx_mmio_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = UART_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    input  logic                     clear,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (clear) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // Storage array; no reset needed since empty gates every read.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_mmio_ctrl.sv
// Memory-mapped UART transmitter: register decode, TX FIFO and an 8N1
// serializer with a programmable per-bit clock divisor.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | line high; pops the next byte when enabled and data is queued
// START | start bit (txd=0) for div_q cycles
// DATA  | eight data bits, LSB first, div_q cycles each
// STOP  | stop bit (txd=1) for div_q cycles, then back to IDLE
module uart_tx_mmio_ctrl
    import uart_tx_mmio_ctrl_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] BAUD_RESET = 16'd868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        sel,
    output logic        txd,
    output logic        irq_tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    uart_reg_address_t reg_off;
    logic              wr_acc;
    logic              rd_acc;
    logic [31:0]       status_word;
    logic [31:0]       rd_mux;
    logic              wdata_unused;

    logic              tx_en_q;
    logic              irq_en_q;
    logic              ovf_q;
    logic [15:0]       baud_q;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_clear;
    logic              fifo_full;
    logic              fifo_empty;
    logic [7:0]        fifo_head;
    logic [CW-1:0]     fifo_count;

    uart_tx_state_t    state_q;
    uart_tx_state_t    state_nxt;
    logic [7:0]        shift_q;
    logic [7:0]        shift_nxt;
    logic [2:0]        bit_q;
    logic [2:0]        bit_nxt;
    logic [15:0]       baud_cnt_q;
    logic [15:0]       baud_cnt_nxt;
    logic [15:0]       div_q;
    logic [15:0]       div_nxt;
    logic              baud_tick;
    logic              txd_q;
    logic              txd_nxt;
    logic              busy;

    assign sel          = (addr[31:4] == UART_BASE_ADDRESS);
    assign reg_off      = uart_reg_address_t'(addr[3:0]);
    assign busy         = (state_q != IDLE);
    assign txd          = txd_q;
    assign wdata_unused = ^wdata[31:16];

    // Bus access qualification; a write in the same cycle swallows the read.
    always_comb begin
        wr_acc     = sel & wr_en;
        rd_acc     = sel & rd_en & ~wr_en;
        fifo_push  = wr_acc & (reg_off == REG_DATA);
        fifo_clear = wr_acc & (reg_off == REG_CTRL) & wdata[CTRL_FIFO_CLR_BIT];
    end

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (wdata[7:0]),
        .pop       (fifo_pop),
        .clear     (fifo_clear),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Control/configuration registers and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_en_q  <= 1'b0;
            irq_en_q <= 1'b0;
            baud_q   <= BAUD_RESET;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_acc) begin
                case (reg_off)
                    REG_STATUS: begin
                        if (wdata[STATUS_OVF_BIT]) begin
                            ovf_q <= 1'b0;
                        end
                    end
                    REG_CTRL: begin
                        tx_en_q  <= wdata[CTRL_TX_EN_BIT];
                        irq_en_q <= wdata[CTRL_IRQ_EN_BIT];
                    end
                    REG_BAUD: baud_q <= wdata[15:0];
                    default: ;
                endcase
            end
            // A byte is lost only if the FIFO stays full and is not being flushed.
            if (fifo_push && fifo_full && !fifo_pop && !fifo_clear) begin
                ovf_q <= 1'b1;
            end
        end
    end

    // STATUS assembly and read-data selection; undefined offsets read zero.
    always_comb begin
        status_word                                    = '0;
        status_word[STATUS_BUSY_BIT]                   = busy;
        status_word[STATUS_FULL_BIT]                   = fifo_full;
        status_word[STATUS_EMPTY_BIT]                  = fifo_empty;
        status_word[STATUS_OVF_BIT]                    = ovf_q;
        status_word[STATUS_COUNT_MSB:STATUS_COUNT_LSB] = 4'(fifo_count);

        rd_mux = '0;
        case (reg_off)
            REG_STATUS: rd_mux = status_word;
            REG_CTRL: begin
                rd_mux[CTRL_TX_EN_BIT]  = tx_en_q;
                rd_mux[CTRL_IRQ_EN_BIT] = irq_en_q;
            end
            REG_BAUD: rd_mux = {16'd0, baud_q};
            default:  rd_mux = '0;
        endcase
    end

    // Registered read port; rdata keeps its value between accepted reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_acc;
            if (rd_acc) begin
                rdata <= rd_mux;
            end
        end
    end

    // Level interrupt once everything queued has left the wire.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_tx <= 1'b0;
        end else begin
            irq_tx <= irq_en_q & fifo_empty & ~busy;
        end
    end

    // Serializer state register; reset forces the line high immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_q      <= '0;
            baud_cnt_q <= '0;
            div_q      <= 16'd1;
            txd_q      <= 1'b1;
        end else begin
            state_q    <= state_nxt;
            shift_q    <= shift_nxt;
            bit_q      <= bit_nxt;
            baud_cnt_q <= baud_cnt_nxt;
            div_q      <= div_nxt;
            txd_q      <= txd_nxt;
        end
    end

    // Serializer next-state logic; txd is derived from the next state so it
    // changes on the same edge as the state register.
    always_comb begin
        state_nxt    = state_q;
        shift_nxt    = shift_q;
        bit_nxt      = bit_q;
        baud_cnt_nxt = baud_cnt_q;
        div_nxt      = div_q;
        fifo_pop     = 1'b0;
        baud_tick    = (baud_cnt_q == div_q - 16'd1);

        case (state_q)
            IDLE: begin
                // A pop racing a flush would start a frame for a discarded byte.
                if (tx_en_q && !fifo_empty && !fifo_clear) begin
                    fifo_pop     = 1'b1;
                    shift_nxt    = fifo_head;
                    div_nxt      = baud_div_eff(baud_q);
                    baud_cnt_nxt = '0;
                    bit_nxt      = '0;
                    state_nxt    = START;
                end
            end
            START: begin
                baud_cnt_nxt = baud_tick ? 16'd0 : baud_cnt_q + 16'd1;
                if (baud_tick) begin
                    state_nxt = DATA;
                end
            end
            DATA: begin
                baud_cnt_nxt = baud_tick ? 16'd0 : baud_cnt_q + 16'd1;
                if (baud_tick) begin
                    shift_nxt = {1'b0, shift_q[7:1]};
                    bit_nxt   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                baud_cnt_nxt = baud_tick ? 16'd0 : baud_cnt_q + 16'd1;
                if (baud_tick) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            START:   txd_nxt = 1'b0;
            DATA:    txd_nxt = shift_nxt[0];
            default: txd_nxt = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_mmio_ctrl.sv
// Scoreboard bench for uart_tx_mmio_ctrl: bytes expected on the wire are
// queued as they are written, and a line monitor pops and checks each frame.
module tb_uart_tx_mmio_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        wr_en = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        sel;
    logic        txd;
    logic        irq_tx;

    uart_tx_mmio_ctrl #(
        .FIFO_DEPTH (4),
        .BAUD_RESET (16'd868)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .addr   (addr),
        .wdata  (wdata),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .rdata  (rdata),
        .rvalid (rvalid),
        .sel    (sel),
        .txd    (txd),
        .irq_tx (irq_tx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] data;
        int         div;
    } frame_t;

    frame_t sb[$];
    int     start_cyc[$];
    int     last_stop_cyc = 0;
    logic   mon_busy = 1'b0;
    int     n_checks = 0;
    int     n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] d, input int dv);
        frame_t f;
        f.data = d;
        f.div  = dv;
        sb.push_back(f);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic v);
        @(negedge clk);
        addr  = a;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        d = rdata;
        v = rvalid;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        logic        v;
        bus_read(a, d, v);
        check_eq({tag, "_rvalid"}, 32'(v), 32'd1);
        check_eq(tag, d, exp);
    endtask

    task automatic wait_drain(input int budget);
        logic done;
        done = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (sb.size() == 0 && !mon_busy) begin
                done = 1'b1;
                break;
            end
        end
        check_eq("drain_in_time", 32'(done), 32'd1);
    endtask

    // Line monitor: every falling edge on an idle line must be a queued frame.
    initial begin : monitor
        logic [9:0] bits;
        frame_t     f;
        forever begin
            @(negedge clk);
            if (rst_n && txd === 1'b0 && !mon_busy) begin
                check_eq("frame_queued", 32'(sb.size() > 0), 32'd1);
                if (sb.size() == 0) begin
                    for (int k = 0; k < 200; k++) begin
                        @(negedge clk);
                        if (!rst_n || txd === 1'b1) break;
                    end
                end else begin
                    mon_busy = 1'b1;
                    f = sb.pop_front();
                    start_cyc.push_back(cyc);
                    bits = {1'b1, f.data, 1'b0};
                    for (int i = 1; i < 10 * f.div; i++) begin
                        @(negedge clk);
                        if (!rst_n) break;
                        check_eq("txd_bit", 32'(txd), 32'(bits[i / f.div]));
                    end
                    last_stop_cyc = cyc;
                    mon_busy = 1'b0;
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] d;
        logic        v;
        logic        irq_seen;
        int          irq_cyc;

        repeat (3) @(negedge clk);
        check_eq("reset_rdata", rdata, 32'd0);
        check_eq("reset_rvalid", 32'(rvalid), 32'd0);
        check_eq("reset_txd", 32'(txd), 32'd1);
        check_eq("reset_irq", 32'(irq_tx), 32'd0);
        rst_n = 1'b1;

        // idle status after reset
        read_check("t1_status", 32'h200, 32'h0000_0004);
        check_eq("t1_txd", 32'(txd), 32'd1);

        // single frame at 4 clocks per bit
        bus_write(32'h20C, 32'd4);
        bus_write(32'h208, 32'h1);
        push_exp(8'hA5, 4);
        bus_write(32'h204, 32'hA5);
        read_check("t2_status_busy", 32'h200, 32'h0000_0005);
        wait_drain(2000);
        read_check("t2_status_idle", 32'h200, 32'h0000_0004);

        // overflow with transmitter disabled
        bus_write(32'h208, 32'h0);
        for (int i = 0; i < 5; i++) bus_write(32'h204, 32'h11 + i);
        read_check("t3_status_full", 32'h200, 32'h0000_004A);
        bus_write(32'h200, 32'h8);
        read_check("t3_ovf_clear", 32'h200, 32'h0000_0042);
        read_check("t3_data_read", 32'h204, 32'h0);
        read_check("t3_undef_read", 32'h202, 32'h0);
        @(negedge clk);
        addr  = 32'h20C;
        wdata = 32'h10;
        wr_en = 1'b1;
        rd_en = 1'b1;
        @(negedge clk);
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_eq("t3_wr_rd_rvalid", 32'(rvalid), 32'd0);
        read_check("t3_baud", 32'h20C, 32'h10);
        bus_write(32'h208, 32'h4);
        read_check("t3_flush_status", 32'h200, 32'h0000_0004);
        read_check("t3_ctrl_read", 32'h208, 32'h0);

        // back-to-back frames at 2 clocks per bit, then interrupt
        bus_write(32'h20C, 32'd2);
        start_cyc.delete();
        push_exp(8'h3C, 2);
        bus_write(32'h204, 32'h3C);
        push_exp(8'hC3, 2);
        bus_write(32'h204, 32'hC3);
        check_eq("t4_irq_before", 32'(irq_tx), 32'd0);
        bus_write(32'h208, 32'h3);
        wait_drain(2000);
        check_eq("t4_frames", 32'(start_cyc.size()), 32'd2);
        if (start_cyc.size() == 2) begin
            check_eq("t4_gap", 32'(start_cyc[1] - start_cyc[0]), 32'd21);
        end
        irq_seen = 1'b0;
        irq_cyc  = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (irq_tx) begin
                irq_seen = 1'b1;
                irq_cyc  = cyc;
                break;
            end
        end
        check_eq("t4_irq_seen", 32'(irq_seen), 32'd1);
        check_eq("t4_irq_latency", 32'(irq_cyc - last_stop_cyc), 32'd2);

        // mid-frame divisor change and flush
        bus_write(32'h208, 32'h0);
        bus_write(32'h20C, 32'd4);
        start_cyc.delete();
        push_exp(8'h5A, 4);
        bus_write(32'h204, 32'h5A);
        bus_write(32'h204, 32'h01);
        bus_write(32'h204, 32'h02);
        read_check("t5_count3", 32'h200, 32'h0000_0030);
        bus_write(32'h208, 32'h1);
        repeat (10) @(negedge clk);
        bus_write(32'h20C, 32'd8);
        bus_write(32'h208, 32'h5);
        read_check("t5_flushed_busy", 32'h200, 32'h0000_0005);
        wait_drain(2000);
        repeat (60) @(negedge clk);
        check_eq("t5_frames", 32'(start_cyc.size()), 32'd1);
        read_check("t5_status", 32'h200, 32'h0000_0004);
        read_check("t5_baud", 32'h20C, 32'd8);

        // reset in the middle of a data bit
        push_exp(8'h96, 8);
        bus_write(32'h204, 32'h96);
        repeat (35) @(negedge clk);
        check_eq("t6_txd_low", 32'(txd), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("t6_txd_async", 32'(txd), 32'd1);
        check_eq("t6_rvalid_rst", 32'(rvalid), 32'd0);
        check_eq("t6_rdata_rst", rdata, 32'd0);
        check_eq("t6_irq_rst", 32'(irq_tx), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        read_check("t6_status", 32'h200, 32'h0000_0004);
        read_check("t6_ctrl", 32'h208, 32'h0);
        read_check("t6_baud", 32'h20C, 32'd868);

        // accesses outside the window
        @(negedge clk);
        addr = 32'h300;
        #1;
        check_eq("t6_sel_off", 32'(sel), 32'd0);
        addr = 32'h20C;
        #1;
        check_eq("t6_sel_on", 32'(sel), 32'd1);
        bus_read(32'h300, d, v);
        check_eq("t6_foreign_rvalid", 32'(v), 32'd0);
        check_eq("t6_rdata_hold", d, 32'd868);
        bus_write(32'h30C, 32'd5);
        bus_write(32'h308, 32'h3);
        bus_write(32'h304, 32'h77);
        repeat (20) @(negedge clk);
        read_check("t6_status_after", 32'h200, 32'h0000_0004);
        read_check("t6_baud_after", 32'h20C, 32'd868);
        read_check("t6_ctrl_after", 32'h208, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_mmio_ctrl.md
Name: uart_tx_mmio_ctrl

Overview:
Memory-mapped UART transmit controller on the core's data bus.
- Decodes accesses whose upper address bits match UART_BASE_ADDRESS.
- Holds the STATUS, DATA, CTRL and BAUD registers.
- Buffers bytes in a small TX FIFO and sequences a serializer FSM that drives the txd line.
- Raises a level interrupt when transmission drains.

Parameters:
FIFO_DEPTH, 4, TX FIFO entries (power of two, ≥2)
BAUD_RESET, 16'd868, reset value of BAUD divisor (clk cycles per bit)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
addr  input  32  byte address from core data bus
wdata  input  32  write data
wr_en  input  1  write strobe, one cycle per access
rd_en  input  1  read strobe, one cycle per access
rdata  output  32  registered read data
rvalid  output  1  high one cycle after an accepted read
sel  output  1  combinational: addr[31:4] == UART_BASE_ADDRESS
txd  output  1  serial output, idle high
irq_tx  output  1  level interrupt

Behaviour:
Reset:
- rdata=0, rvalid=0, txd=1, irq_tx=0.
- FIFO empty; FSM=IDLE; CTRL=0; BAUD=BAUD_RESET; overflow=0.
- Reset mid-frame aborts the frame; txd returns high asynchronously.

Decode:
- Access is accepted only when sel=1; offset = addr[3:0] as uart_reg_address_t.
- Undefined offsets: writes ignored, reads return 0.
- wr_en and rd_en in the same cycle: write wins, read is dropped (rvalid=0).

Registers:
- STATUS (0x0), read-only except bit3:
  - bit0 busy (FSM≠IDLE)
  - bit1 fifo_full
  - bit2 fifo_empty
  - bit3 overflow (sticky; writing 1 clears it)
  - bits[7:4] fifo count
- DATA (0x4): write pushes wdata[7:0]. Write while full: byte dropped, overflow set. Reads return 0.
- CTRL (0x8):
  - bit0 tx_en
  - bit1 irq_en
  - bit2 fifo_clear: write-1 flushes the FIFO that cycle, self-clears, always reads 0
- BAUD (0xC): bits[15:0] divisor; reads return the zero-extended value.

Read timing:
- rdata/rvalid are registered one cycle after rd_en.
- rdata holds its value until the next accepted read.

Interrupt:
- irq_tx = irq_en & fifo_empty & ~busy (registered).

Serializer FSM:
- IDLE:
  - If tx_en & ~fifo_empty: pop head byte into the shift register.
  - Latch the divisor into div_q, treating 0 as 1.
  - Go to START.
- START: txd=0 for div_q cycles, then go to DATA.
- DATA: 8 bits LSB first, div_q cycles each; a 3-bit bit counter advances on bit-tick; after bit 7 go to STOP.
- STOP: txd=1 for div_q cycles, then go to IDLE.
- Frame length: 10·div_q cycles plus 1 IDLE cycle between back-to-back frames.
- Baud counter: 16-bit, counts 0..div_q-1 and reloads on tick. A BAUD write mid-frame affects only the next frame.

Mid-frame events:
- tx_en cleared mid-frame: the current frame completes; no further pop.
- fifo_clear mid-frame: the current frame completes; the queued bytes are discarded.

FIFO boundaries:
- Simultaneous push and pop when full: both succeed, count unchanged, no overflow.
- Simultaneous push and pop when empty: push only.
- Simultaneous push and fifo_clear: clear wins, so the pushed byte is discarded.
- Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.

Decomposition:
- Shared package: reuse UART_BASE_ADDRESS and uart_reg_address_t. Add to the package:
  - the uart_tx_state_t enum (IDLE, START, DATA, STOP)
  - STATUS bit-index constants
  - CTRL bit-index constants
- Sub-module: uart_tx_fifo (synchronous FIFO with push/pop/clear/full/empty/count), instantiated once.

Test Plan:
- Reset, then read STATUS at 0x200 → rvalid one cycle later; rdata=0x00000004 (empty, idle); txd=1.
- BAUD=4, CTRL=1, write DATA=0xA5 → txd sequence, 4 cycles per bit: 0, 1,0,1,0,0,1,0,1, 1; busy high 40 cycles; STATUS returns 0x4 afterwards.
- FIFO_DEPTH=4, tx_en=0, write DATA 5 times (0x11..0x15) → STATUS=0x4A (count 4, full, overflow). Write STATUS=0x8 → overflow cleared.
- irq_en=1, tx_en=1, BAUD=2, two bytes queued → two frames of 20 cycles each separated by 1 idle cycle; irq_tx rises one cycle after the second STOP ends.
- Mid-frame BAUD write (4→8) and fifo_clear with 2 bytes queued → current frame keeps 4 cycles/bit; no further frames; STATUS count=0.
- rst_n asserted during DATA → txd=1 immediately and all registers return to reset values; access at 0x300 → sel=0, no rvalid, no state change.
